// File: rtl/mmio_uart_tx_if.sv
// Load/store data-port bundle between the EXU and the memory-mapped UART transmitter.
interface mmio_uart_tx_if #(
  parameter int unsigned XLEN = 32
) ();

  logic [XLEN-1:0] raddr;
  logic            rvalid_in;
  logic [XLEN-1:0] rdata;
  logic            rvalid_out;
  logic [XLEN-1:0] waddr;
  logic            wen;
  logic [XLEN-1:0] wdata;

  // EXU side: issues reads and writes, receives read data
  modport master (
    output raddr, rvalid_in, waddr, wen, wdata,
    input  rdata, rvalid_out
  );

  // Peripheral side: answers reads, absorbs writes
  modport slave (
    input  raddr, rvalid_in, waddr, wen, wdata,
    output rdata, rvalid_out
  );

endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: store-written bytes go into a FIFO and
// are shifted out LSB first on tx; STATUS exposes fill level and flags.
module mmio_uart_tx #(
  parameter int unsigned    XLEN         = 32,
  parameter logic [XLEN-1:0] BASE_ADDR    = XLEN'(32'h9000_0000),
  parameter int unsigned    CLKS_PER_BIT = 16,
  parameter int unsigned    FIFO_DEPTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mmio_uart_tx_if.slave        bus,
  output logic                 tx
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TMR_W = $clog2(CLKS_PER_BIT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;

  // FIFO storage and bookkeeping
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;

  // Serialiser state
  logic [1:0]       state_q,  state_d;
  logic [TMR_W-1:0] tmr_q,    tmr_d;
  logic [2:0]       bit_q,    bit_d;
  logic [7:0]       shift_q,  shift_d;
  logic             tx_d;
  logic             pop_c;

  // Decode and derived flags
  logic             rd_hit_c;
  logic             wr_hit_c;
  logic             push_req_c;
  logic             push_ok_c;
  logic             ovf_clr_c;
  logic             full_c;
  logic             empty_c;
  logic             busy_c;
  logic             bit_end_c;
  logic [15:0]      status_c;
  logic [XLEN-1:0]  rd_val_c;
  logic             unused_bits;

  assign rd_hit_c   = (bus.raddr[XLEN-1:4] == BASE_ADDR[XLEN-1:4]);
  assign wr_hit_c   = (bus.waddr[XLEN-1:4] == BASE_ADDR[XLEN-1:4]);
  assign push_req_c = bus.wen && wr_hit_c && (bus.waddr[3:2] == OFF_TXDATA);
  assign ovf_clr_c  = bus.wen && wr_hit_c && (bus.waddr[3:2] == OFF_STATUS) && bus.wdata[3];
  assign full_c     = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_c    = (count_q == '0);
  assign busy_c     = (state_q != S_IDLE);
  // A full FIFO still accepts a byte when the serialiser drains one in the same cycle
  assign push_ok_c  = push_req_c && (!full_c || pop_c);
  assign bit_end_c  = (tmr_q == TMR_W'(CLKS_PER_BIT - 1));
  assign status_c   = {8'(count_q), 4'b0000, overflow_q, busy_c, empty_c, full_c};

  // Address bits below word granularity and upper write-data bits carry no meaning here
  assign unused_bits = ^{bus.raddr[1:0], bus.waddr[1:0], bus.wdata[XLEN-1:8]};

  // Read data mux: only STATUS returns non-zero content
  always_comb begin
    rd_val_c = '0;
    if (rd_hit_c && (bus.raddr[3:2] == OFF_STATUS)) begin
      rd_val_c = XLEN'(status_c);
    end
  end

  // Read response: one-cycle pulse per request, data held between responses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.rvalid_out <= 1'b0;
      bus.rdata      <= '0;
    end else begin
      bus.rvalid_out <= bus.rvalid_in;
      if (bus.rvalid_in) begin
        bus.rdata <= rd_val_c;
      end
    end
  end

  // FIFO payload storage
  always_ff @(posedge clk) begin
    if (push_ok_c) begin
      mem[wr_ptr_q] <= bus.wdata[7:0];
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok_c) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok_c, pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (push_req_c && !push_ok_c) begin
        overflow_q <= 1'b1;
      end else if (ovf_clr_c) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // Serialiser next-state: frame sequencing, bit timing and FIFO pop
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop_c   = 1'b0;
    tx_d    = 1'b1;
    case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        if (!empty_c) begin
          pop_c   = 1'b1;
          shift_d = mem[rd_ptr_q];
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end_c) begin
          tmr_d   = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end_c) begin
          tmr_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end_c) begin
          tmr_d = '0;
          // Chain straight into the next frame so queued bytes leave back to back
          if (!empty_c) begin
            pop_c   = 1'b1;
            shift_d = mem[rd_ptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tmr_d   = '0;
      end
    endcase
    // Line level follows the upcoming state so the registered pin tracks the FSM exactly
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // Serialiser state register and registered line driver
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx      <= 1'b1;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx      <= tx_d;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: read responses and received UART bytes are
// checked by monitors against queues filled when stimulus is issued.
module tb_mmio_uart_tx;

  localparam int unsigned CPB    = 4;
  localparam int unsigned DEPTH  = 8;
  localparam logic [31:0] A_TX   = 32'h9000_0000;
  localparam logic [31:0] A_ST   = 32'h9000_0004;
  localparam logic [31:0] A_RSV8 = 32'h9000_0008;
  localparam logic [31:0] A_RSVC = 32'h9000_000C;
  localparam logic [31:0] A_MISS = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd_q [$];
  logic [7:0]  rx_q [$];
  bit          rx_en = 1'b1;
  logic        req_seen = 1'b0;

  always #5 clk = ~clk;

  mmio_uart_tx_if #(.XLEN(32)) bus ();

  mmio_uart_tx #(
    .XLEN(32),
    .BASE_ADDR(32'h9000_0000),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .tx(tx)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus.waddr = addr;
    bus.wdata = data;
    bus.wen   = 1'b1;
    tick();
    bus.wen   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
    bus.raddr     = addr;
    bus.rvalid_in = 1'b1;
    rd_q.push_back(exp);
    tick();
    bus.rvalid_in = 1'b0;
  endtask

  task automatic rdwr(input logic [31:0] raddr, input logic [31:0] exp,
                      input logic [31:0] waddr, input logic [31:0] wdata);
    bus.raddr     = raddr;
    bus.rvalid_in = 1'b1;
    bus.waddr     = waddr;
    bus.wdata     = wdata;
    bus.wen       = 1'b1;
    rd_q.push_back(exp);
    tick();
    bus.rvalid_in = 1'b0;
    bus.wen       = 1'b0;
  endtask

  // Bounded wait for a start bit on the line
  task automatic wait_start(input string name);
    for (int i = 0; i < 64; i++) begin
      if (tx === 1'b0) return;
      tick();
    end
    checks++;
    errors++;
    $display("FAIL %s: got no start bit expected tx=0 within 64 cycles", name);
  endtask

  // Request tracker for response latency
  always @(posedge clk) req_seen <= bus.rvalid_in;

  // Read-response monitor
  always @(negedge clk) begin
    if (bus.rvalid_out === 1'b1 || req_seen) begin
      check("rvalid_latency", 32'(bus.rvalid_out), 32'(req_seen));
    end
    if (bus.rvalid_out === 1'b1) begin
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got rdata 0x%08h expected no response", bus.rdata);
      end else begin
        check("rdata", bus.rdata, rd_q.pop_front());
      end
    end
  end

  // UART receiver: samples mid-bit and checks each frame against the expected bytes
  always begin : rx_mon
    logic       tx_prev;
    logic       s0;
    logic       st;
    logic [7:0] b;
    tx_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && tx_prev === 1'b1 && tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        s0 = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        st = tx;
        if (rx_en) begin
          check("rx_start_bit", 32'(s0), 32'h0);
          check("rx_stop_bit", 32'(st), 32'h1);
          if (rx_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected: got byte 0x%02h expected no frame", b);
          end else begin
            check("rx_byte", 32'(b), 32'(rx_q.pop_front()));
          end
        end
      end
      tx_prev = tx;
    end
  end

  // Stimulus
  initial begin
    int bad;
    logic [7:0] v55;
    logic       exp_bit;
    bus.raddr     = '0;
    bus.rvalid_in = 1'b0;
    bus.waddr     = '0;
    bus.wen       = 1'b0;
    bus.wdata     = '0;
    rst_n         = 1'b0;
    repeat (3) tick();

    // Reset state
    check("reset_tx", 32'(tx), 32'h1);
    check("reset_rvalid", 32'(bus.rvalid_out), 32'h0);
    check("reset_rdata", bus.rdata, 32'h0);
    rst_n = 1'b1;
    rd(A_ST, 32'h0000_0002);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (tx !== 1'b1) bad++;
      tick();
    end
    check("idle_tx_high", 32'(bad), 32'h0);

    // Single frame 0x55 with cycle-exact line check
    v55 = 8'h55;
    rx_q.push_back(v55);
    wr(A_TX, 32'h55);
    check("tx_before_start", 32'(tx), 32'h1);
    for (int k = 0; k < 40; k++) begin
      tick();
      if (k < 4)       exp_bit = 1'b0;
      else if (k < 36) exp_bit = v55[(k - 4) / 4];
      else             exp_bit = 1'b1;
      check($sformatf("frame55_c%0d", k + 2), 32'(tx), 32'(exp_bit));
    end
    rd(A_ST, 32'h0000_0006);
    rd(A_ST, 32'h0000_0002);

    // Fill past depth: 9 accepted thanks to the early pop, 10th overflows
    for (int i = 0; i < 9; i++) begin
      rx_q.push_back(8'(8'h10 + i));
      wr(A_TX, 32'(8'h10 + i));
    end
    wr(A_TX, 32'hEE);
    rd(A_ST, 32'h0000_080D);
    wr(A_ST, 32'h0000_0008);
    rd(A_ST, 32'h0000_0805);
    repeat (9 * 10 * CPB + 10) tick();
    rd(A_ST, 32'h0000_0002);

    // Back-to-back frames: next start bit exactly 40 cycles after the first
    rx_q.push_back(8'hA5);
    rx_q.push_back(8'h3C);
    wr(A_TX, 32'hA5);
    wr(A_TX, 32'h3C);
    wait_start("first_start");
    repeat (36) tick();
    for (int j = 0; j < 4; j++) begin
      check($sformatf("stop_gap_%0d", j), 32'(tx), 32'h1);
      tick();
    end
    check("second_start_at_40", 32'(tx), 32'h0);
    repeat (50) tick();

    // Misses, reserved offsets, read/write in the same cycle
    rd(A_MISS, 32'h0);
    rd(A_RSVC, 32'h0);
    wr(A_RSV8, 32'hFF);
    wr(A_MISS, 32'h41);
    rd(A_ST, 32'h0000_0002);
    rx_q.push_back(8'h0F);
    rdwr(A_ST, 32'h0000_0002, A_TX, 32'h0F);
    rd(A_ST, 32'h0000_0100);
    rd(A_ST, 32'h0000_0006);
    repeat (50) tick();

    // Reset during data bit 3 aborts the frame
    rx_en = 1'b0;
    wr(A_TX, 32'hC3);
    wait_start("abort_start");
    repeat (17) tick();
    rst_n = 1'b0;
    tick();
    check("reset_midframe_tx", 32'(tx), 32'h1);
    rst_n = 1'b1;
    rd(A_ST, 32'h0000_0002);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      if (tx !== 1'b1) bad++;
      tick();
    end
    check("no_residual_frame", 32'(bad), 32'h0);

    repeat (3) tick();
    check("rd_queue_drained", 32'(rd_q.size()), 32'h0);
    check("rx_queue_drained", 32'(rx_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter. It is the responder on the EXU load/store data-port protocol: raddr/rvalid_in → rdata/rvalid_out, and waddr/wen/wdata.
- Sits beside dccm on the EXU data port. Top-level decode steers a fixed address window to it.
- Buffers store-written bytes in a FIFO and serialises them 8N1 on a single tx pin.
- Gives firmware a console output path without a bus fabric.

Parameters:
- BASE_ADDR, 32'h9000_0000, window base; bits [3:0] must be 0; window is 16 bytes.
- CLKS_PER_BIT, 16, clk cycles per UART bit; legal range 2..65535.
- FIFO_DEPTH, 8, TX byte FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset; synchronous, active-low.
- raddr  in  XLEN  read byte address.
- rvalid_in  in  1  read request strobe.
- rdata  out  XLEN  read data, registered.
- rvalid_out  out  1  read response valid.
- waddr  in  XLEN  write byte address.
- wen  in  1  write strobe.
- wdata  in  XLEN  write data.
- tx  out  1  UART serial output; idle high.

Behaviour:
- Reset (rst_n=0 sampled at posedge):
  - rdata=0, rvalid_out=0, tx=1.
  - FIFO emptied (count=0), overflow=0, FSM=IDLE, bit/clock counters=0.
  - Reset mid-frame aborts the frame; tx=1 on the first clock after reset.
- Decode: hit when addr[XLEN-1:4]==BASE_ADDR[XLEN-1:4]. Register offset is addr[3:2]; addr[1:0] is ignored.
- Register map:
  - 0x0 TXDATA: W = push wdata[7:0]; R = 0.
  - 0x4 STATUS: R = {count[15:8], 4'b0, overflow[3], busy[2], empty[1], full[0]}, zero-extended. W: wdata[3]=1 clears overflow (W1C); other bits ignored.
  - 0x8, 0xC: reserved. R = 0; W ignored.
- Read responses:
  - Every rvalid_in produces rvalid_out=1 exactly 1 cycle later. This includes misses and reserved offsets, which return 0.
  - rvalid_out is a single-cycle pulse per request. Back-to-back reads are supported, one per cycle.
  - rdata reflects state before any same-cycle write. rdata holds its value while rvalid_out=0.
- Writes: no response and no stall; a write completes in the cycle wen is sampled.
- Push to TXDATA:
  - Accepted if !full, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set (sticky).
  - Overflow set and W1C clear cannot coincide, since only one write happens per cycle.
- FIFO:
  - count has width $clog2(FIFO_DEPTH+1).
  - full = count==FIFO_DEPTH; empty = count==0.
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - A simultaneous push and pop leaves count unchanged.
- FSM states: IDLE, START, DATA, STOP. Bit timer counts 0..CLKS_PER_BIT-1.
  - IDLE: tx=1. If !empty: pop into shift register, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end: if !empty, pop and go directly to START (no idle gap); else go to IDLE.
  - busy = (state != IDLE).
- Timing:
  - tx is registered.
  - A write to an empty, idle block at cycle N makes empty=0 at N+1. The pop happens at N+1, and tx falls at N+2.
  - Frame length is 10*CLKS_PER_BIT cycles. Consecutive queued bytes are exactly 10*CLKS_PER_BIT cycles apart.
- Implementation constraints: no combinational path from inputs to outputs. No internal clock gating.

Test Plan:
- Reset, then read STATUS: rvalid_out=1 one cycle later, rdata=32'h0000_0002, tx=1 constant.
- CLKS_PER_BIT=4; write 0x55 to 0x9000_0000 at cycle N: tx=0 over N+2..N+5, then bits 1,0,1,0,1,0,1,0 of 4 cycles each, stop=1, busy clears at N+42.
- Write 9 bytes back-to-back (DEPTH=8) while idle: first byte pops at N+1, so 9 are accepted and no overflow. Write a 10th immediately: it is dropped, and STATUS reads count=8, full=1, overflow=1. Write 0x8 to 0x9000_0004: overflow=0.
- Queue 0xA5 then 0x3C: second start bit begins exactly 40 cycles after the first (CLKS_PER_BIT=4) and tx does not pulse high between them beyond the stop bit.
- Read 0x8000_0000 (miss) and 0x9000_000C (reserved): both give rvalid_out pulses with rdata=0. A read of 0x9000_0004 in the same cycle as a TXDATA write returns the pre-write count.
- Assert rst_n=0 during DATA bit 3: tx=1 the next cycle, STATUS=0x2 afterwards, and no residual frame is sent.
